// File: rtl/r5p_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : r5p_uart_rx                                                |
// | Description : UART receiver (8N1, optionally 8E1) with a small elastic   |
// |               FIFO and a valid/ready byte stream output. Line errors and |
// |               FIFO overflow are reported as one-cycle pulses.            |
// | Options     : define R5P_UART_RX_PARITY_EN to compile in even parity     |
// |               (8E1 framing, err_par active).                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module r5p_uart_rx #(
  parameter int BDR = 234,  // clock cycles per bit, 4..65535
  parameter int FDP = 4     // FIFO depth in bytes, power of 2, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rxd,
  output logic                       rx_vld,
  output logic [7:0]                 rx_dat,
  input  logic                       rx_rdy,
  output logic [$clog2(FDP+1)-1:0]   rx_cnt,
  output logic                       err_frm,
  output logic                       err_ovf,
  output logic                       err_par
);

  localparam int AW = $clog2(FDP);
  localparam int CW = $clog2(FDP + 1);

  // Counter reload values: half a bit to reach the start-bit centre, then a
  // full bit between all subsequent samples.
  localparam logic [15:0] C_HALF    = 16'(BDR / 2 - 1);
  localparam logic [15:0] C_FULL    = 16'(BDR - 1);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef R5P_UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       rxd_s;

  // Next value of the synchronizer chain: rxd enters at bit 0.
  always_comb begin
    sync_d = {sync_q[0], rxd};
  end

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rxd_s = sync_q[1];

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shr_q;
  logic        err_frm_q;
  logic        err_par_q;
`ifdef R5P_UART_RX_PARITY_EN
  logic        par_err_q;
`endif

  logic        cnt_zero;
  logic        push_req;

  // Sample strobe and the request to store a completed good byte. The push is
  // combinational so the FIFO write lands on the same edge as the stop sample.
  always_comb begin
    cnt_zero = (cnt_q == 16'd0);
    push_req = (state_q == S_STOP) && cnt_zero && rxd_s;
`ifdef R5P_UART_RX_PARITY_EN
    if (par_err_q) begin
      push_req = 1'b0;
    end
`endif
  end

  // Frame sequencing: start-bit qualification, data shifting, optional
  // parity check, stop-bit check and break recovery. Error pulses are
  // registered here so they appear the cycle after the offending sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shr_q     <= 8'd0;
      err_frm_q <= 1'b0;
      err_par_q <= 1'b0;
`ifdef R5P_UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      err_frm_q <= 1'b0;
      err_par_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_q <= S_START;
            cnt_q   <= C_HALF;
          end
        end

        S_START: begin
          if (cnt_zero) begin
            if (rxd_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              cnt_q     <= C_FULL;
              idx_q     <= 3'd0;
`ifdef R5P_UART_RX_PARITY_EN
              par_err_q <= 1'b0;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_DATA: begin
          if (cnt_zero) begin
            shr_q <= {rxd_s, shr_q[7:1]};
            cnt_q <= C_FULL;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef R5P_UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

`ifdef R5P_UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_zero) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_err_q <= (rxd_s != (^shr_q));
            cnt_q     <= C_FULL;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (cnt_zero) begin
            if (rxd_s) begin
              // Return to IDLE at mid stop bit, leaving half a bit of slack
              // for the next start edge.
              state_q <= S_IDLE;
`ifdef R5P_UART_RX_PARITY_EN
              err_par_q <= par_err_q;
`endif
            end else begin
              err_frm_q <= 1'b1;
              state_q   <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_BREAK: begin
          if (rxd_s) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign err_frm = err_frm_q;
`ifdef R5P_UART_RX_PARITY_EN
  assign err_par = err_par_q;
`else
  assign err_par = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Elastic FIFO
  // --------------------------------------------------------------------------
  logic [AW:0] wptr_q;
  logic [AW:0] wptr_d;
  logic [AW:0] rptr_q;
  logic [AW:0] rptr_d;
  logic [7:0]  mem_q [FDP];
  logic [7:0]  mem_d [FDP];
  logic        ovf_q;
  logic        ovf_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_pop;
  logic        fifo_wr;

  // Pointer and storage update. The extra pointer bit separates full from
  // empty; a push into a full FIFO is only accepted when a pop frees a slot
  // on the same edge.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    fifo_pop   = !fifo_empty && rx_rdy;
    fifo_wr    = push_req && (!fifo_full || fifo_pop);
    ovf_d      = push_req && fifo_full && !fifo_pop;
    wptr_d     = fifo_wr  ? (wptr_q + C_PTR_ONE) : wptr_q;
    rptr_d     = fifo_pop ? (rptr_q + C_PTR_ONE) : rptr_q;
    mem_d      = mem_q;
    if (fifo_wr) begin
      mem_d[wptr_q[AW-1:0]] = shr_q;
    end
  end

  // FIFO state registers; reset clears pointers and storage so rx_dat reads
  // zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FDP; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      mem_q  <= mem_d;
    end
  end

  assign rx_vld  = !fifo_empty;
  assign rx_dat  = mem_q[rptr_q[AW-1:0]];
  assign rx_cnt  = CW'(wptr_q - rptr_q);
  assign err_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_r5p_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_r5p_uart_rx                                             |
// | Description : Scoreboard bench for r5p_uart_rx (BDR=8, FDP=4). Frames    |
// |               are modelled at byte level; a monitor pops the expected    |
// |               queue whenever the DUT hands over a byte.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_r5p_uart_rx;

  localparam int BDR = 8;
  localparam int FDP = 4;
  localparam int CW  = $clog2(FDP + 1);

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          rxd    = 1'b1;
  logic          rx_rdy = 1'b0;
  logic          rx_vld;
  logic [7:0]    rx_dat;
  logic [CW-1:0] rx_cnt;
  logic          err_frm;
  logic          err_ovf;
  logic          err_par;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int exp_frm  = 0;
  int exp_ovf  = 0;
  int exp_par  = 0;
  int seen_frm = 0;
  int seen_ovf = 0;
  int seen_par = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  r5p_uart_rx #(.BDR(BDR), .FDP(FDP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxd    (rxd),
    .rx_vld (rx_vld),
    .rx_dat (rx_dat),
    .rx_rdy (rx_rdy),
    .rx_cnt (rx_cnt),
    .err_frm(err_frm),
    .err_ovf(err_ovf),
    .err_par(err_par)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready, changed well after the active edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       rx_rdy = 1'b0;
      1:       rx_rdy = 1'b1;
      default: rx_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and counts error pulses,
  // flagging any pulse wider than one cycle.
  initial begin
    logic pf;
    logic po;
    logic pp;
    logic [7:0] e;
    pf = 1'b0; po = 1'b0; pp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pf = 1'b0; po = 1'b0; pp = 1'b0;
      end else begin
        if (rx_vld && rx_rdy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected none", rx_dat);
          end else begin
            e = exp_q.pop_front();
            chk("rx_dat", {24'd0, rx_dat}, {24'd0, e});
          end
        end
        if (err_frm) begin seen_frm++; chk("err_frm_width", {31'd0, pf}, 32'd0); end
        if (err_ovf) begin seen_ovf++; chk("err_ovf_width", {31'd0, po}, 32'd0); end
        if (err_par) begin seen_par++; chk("err_par_width", {31'd0, pp}, 32'd0); end
        pf = err_frm; po = err_ovf; pp = err_par;
      end
    end
  end

  // Byte-level reference: what the receiver must do with one frame.
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                                  exp_frm++;
    else if (!par_ok)                              exp_par++;
    else if (rdy_mode == 0 && exp_q.size() == FDP) exp_ovf++;
    else                                           exp_q.push_back(b);
  endfunction

  task automatic send_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int stop_len);
    model_frame(b, stop_ok, par_ok);
    send_bit(1'b0, BDR);
    for (int i = 0; i < 8; i++) send_bit(b[i], BDR);
`ifdef R5P_UART_RX_PARITY_EN
    send_bit((^b) ^ !par_ok, BDR);
`endif
    send_bit(stop_ok, stop_len);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_vld"}, {31'd0, rx_vld}, 32'd0);
    chk({name, "_cnt"}, {{(32-CW){1'b0}}, rx_cnt}, 32'd0);
    chk({name, "_dat"}, {24'd0, rx_dat}, 32'd0);
    chk({name, "_frm"}, {31'd0, err_frm}, 32'd0);
    chk({name, "_ovf"}, {31'd0, err_ovf}, 32'd0);
    chk({name, "_par"}, {31'd0, err_par}, 32'd0);
  endtask

  initial begin
    int n;
    int vld_seen;
    bit sok;
    bit pok;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency and single-cycle valid for 0xA5
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    fork
      send_frame(8'hA5, 1'b1, 1'b1, BDR);
      begin
        n = 0;
        while (n < 300) begin
          @(posedge clk);
          #1;
          n++;
          if (rx_vld) break;
        end
`ifdef R5P_UART_RX_PARITY_EN
        chk("latency", n, 2 + BDR / 2 + 10 * BDR + 1);
`else
        chk("latency", n, 2 + BDR / 2 + 9 * BDR + 1);
`endif
        @(posedge clk);
        #1;
        chk("vld_width", {31'd0, rx_vld}, 32'd0);
      end
    join
    wait_drain("a5");

    // Glitch shorter than half a bit
    send_bit(1'b0, 3);
    vld_seen = 0;
    for (int i = 0; i < 6 * BDR; i++) begin
      send_bit(1'b1, 1);
      if (rx_vld) vld_seen++;
    end
    chk("glitch_vld", vld_seen, 32'd0);
    chk("glitch_frm", seen_frm, exp_frm);

    // Framing error followed by line break, then a good byte
    send_frame(8'h3C, 1'b0, 1'b1, BDR + 20);
    send_bit(1'b1, 2 * BDR);
    send_frame(8'h55, 1'b1, 1'b1, BDR);
    wait_drain("frm");
    repeat (4) @(negedge clk);
    chk("frm_count", seen_frm, exp_frm);

    // Overflow: consumer stalled, five bytes into a four-deep FIFO
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1, BDR);
    repeat (BDR) @(negedge clk);
    chk("ovf_cnt", {{(32-CW){1'b0}}, rx_cnt}, exp_q.size());
    chk("ovf_count", seen_ovf, exp_ovf);
    rdy_mode = 1;
    wait_drain("ovf");
    repeat (4) @(negedge clk);
    chk("ovf_cnt_empty", {{(32-CW){1'b0}}, rx_cnt}, 32'd0);

    // Reset mid-frame with a byte parked in the FIFO
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, BDR);
    repeat (BDR) @(negedge clk);
    chk("park_cnt", {{(32-CW){1'b0}}, rx_cnt}, exp_q.size());
    send_bit(1'b0, BDR);       // start bit of 0xF0
    send_bit(1'b0, 4 * BDR);   // low nibble of 0xF0
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midrst");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1, BDR);
    wait_drain("after_rst");

`ifdef R5P_UART_RX_PARITY_EN
    // Parity: correct then wrong parity bit
    send_frame(8'h07, 1'b1, 1'b1, BDR);
    send_frame(8'h07, 1'b1, 1'b0, BDR);
    wait_drain("par");
    repeat (4) @(negedge clk);
    chk("par_count", seen_par, exp_par);
`endif

    // Randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      sok = ($urandom_range(0, 9) != 0);
`ifdef R5P_UART_RX_PARITY_EN
      pok = ($urandom_range(0, 7) != 0);
`else
      pok = 1'b1;
`endif
      send_frame(8'($urandom), sok, pok, BDR);
      if (!sok) send_bit(1'b1, 2 * BDR);
      else      send_bit(1'b1, $urandom_range(0, BDR));
    end
    rdy_mode = 1;
    wait_drain("rand");
    repeat (2 * BDR) @(negedge clk);
    chk("rand_frm", seen_frm, exp_frm);
    chk("rand_ovf", seen_ovf, exp_ovf);
    chk("rand_par", seen_par, exp_par);
    chk("final_cnt", {{(32-CW){1'b0}}, rx_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/r5p_uart_rx.md
# r5p_uart_rx

Serial UART receiver with a small elastic FIFO, sitting directly upstream of the SoC UART peripheral on the Tang Nano 9k board. It consumes the asynchronous `FPGA_RX` pin and produces bytes on a valid/ready stream for the SoC data path. Framing is fixed 8N1 at a compile-time bit period, optionally 8E1. Line errors and FIFO overflow are reported as single-cycle pulses.

## Interface
- `BDR`, 234: clock cycles per bit (27 MHz / 115200); legal range 4..65535.
- `FDP`, 4: FIFO depth in bytes; power of 2, >= 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `rxd`  in  1  serial input, asynchronous, idle high.
- `rx_vld`  out  1  FIFO head byte valid.
- `rx_dat`  out  8  FIFO head byte.
- `rx_rdy`  in  1  consumer accepts head byte when `rx_vld & rx_rdy`.
- `rx_cnt`  out  $clog2(FDP+1)  FIFO occupancy.
- `err_frm`  out  1  one-cycle pulse on framing error.
- `err_ovf`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `err_par`  out  1  one-cycle pulse on parity error; tied 0 without `R5P_UART_RX_PARITY_EN`.

## Operation
- Input path: 2-flop synchronizer, both flops reset to 1; `rxd_s` lags `rxd` by 2 cycles.
- Bit counter `cnt` (16 bit, down-counting), bit index `idx` (3 bit), shift register `shr` (8 bit, LSB first).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: `rxd_s==0` -> START, `cnt=BDR/2-1` (integer division).
- START: at `cnt==0` sample `rxd_s`; 1 -> IDLE (glitch, no error); 0 -> DATA, `cnt=BDR-1`, `idx=0`.
- DATA: at `cnt==0` shift `rxd_s` into `shr[7]` (right shift), reload `cnt=BDR-1`; after `idx==7` -> PARITY or STOP.
- PARITY: at `cnt==0` compare `rxd_s` with even parity `^shr`; mismatch latched, -> STOP.
- STOP: at `cnt==0` sample; 1 -> push `shr` (unless parity mismatch: drop, pulse `err_par`), -> IDLE immediately; 0 -> pulse `err_frm`, drop byte, -> BREAK.
- BREAK: wait for `rxd_s==1`, then -> IDLE.
- FIFO: `FDP` entries, read/write pointers with extra wrap bit; full = pointers differ only in MSB.
- Push when full without simultaneous pop: byte dropped, `err_ovf` pulses, FIFO unchanged.
- Push when full with simultaneous pop: both happen, no overflow, `rx_cnt` stays `FDP`.
- Push and pop on non-empty non-full FIFO: `rx_cnt` unchanged.
- `rx_dat` = memory at read pointer; undefined-but-stable when empty, consumer must gate on `rx_vld`.

## Timing
- Reset values: `rx_vld=0`, `rx_cnt=0`, `err_*=0`, `rx_dat` = 0 (memory reset), FSM IDLE, sync flops 1.
- `rst_n` assertion mid-frame aborts frame and empties FIFO asynchronously; no error pulse.
- Sample instants relative to cycle t where IDLE sees `rxd_s==0`: start t+BDR/2, data bit i at t+BDR/2+(i+1)*BDR, stop at t+BDR/2+9*BDR (+BDR with parity).
- Push occurs at the stop-sample edge; `rx_vld` rises 1 cycle later, total latency from first `clk` edge sampling `rxd` low = 2+BDR/2+9*BDR+1 (plus BDR with parity).
- Error pulses assert the cycle after the offending sample, exactly 1 cycle wide.
- Back-to-back frames: next start bit accepted the cycle after STOP returns to IDLE (half a stop bit of slack).
- Pop is combinational handshake: head advances on the edge where `rx_vld & rx_rdy`; next byte visible same next cycle.

## Configuration
- `R5P_UART_RX_PARITY_EN` defined: PARITY state compiled in, frame 8E1, `err_par` active.
- Undefined: 8N1, PARITY state and parity logic absent, `err_par` constant 0.

## Test plan
- BDR=8, send 0xA5 8N1, `rx_rdy=1` -> `rx_vld` high exactly 1 cycle at 79 cycles after `rxd` falls, `rx_dat=0xA5`, no errors.
- Glitch: `rxd` low 3 cycles then high -> no `rx_vld`, no error pulse, FSM back in IDLE.
- Send 0x3C with stop bit 0, hold low 20 cycles, release, send 0x55 -> one `err_frm` pulse, no 0x3C output, then 0x55 received.
- FDP=4, `rx_rdy=0`, send 0x01..0x05 -> `rx_cnt=4`, `err_ovf` pulse on 5th; then `rx_rdy=1` drains 0x01,0x02,0x03,0x04.
- Assert `rst_n` low after 4 data bits of 0xF0 -> all outputs at reset values; release, send 0x81 -> 0x81 received, no error.
- With `R5P_UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> received; 0x07 with parity bit 0 -> `err_par` pulse, no byte.
